// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: hunts the bit stream for SYNC_PAT, then shifts in DATA_W payload bits MSB first.
// Optional even-parity bit after the payload is enabled by defining PARITY_CHK_EN.
module serial_frame_receiver #(
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
    parameter int                DATA_W   = 8,
    parameter int                CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              y,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              locked,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              parity_err
);

    // state  | meaning
    // HUNT   | shifting y into sync_sr, waiting for SYNC_PAT after at least SYNC_W bits
    // DATA   | shifting DATA_W payload bits into data_sr
    // PARITY | consuming the even-parity bit (PARITY_CHK_EN builds only)

    localparam int FILL_W = $clog2(SYNC_W + 1);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t            state;
    logic [SYNC_W-1:0] sync_sr;
    logic [FILL_W-1:0] fill_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] data_sr;

    logic [SYNC_W-1:0] sync_next;
    logic [FILL_W-1:0] fill_next;
    logic [DATA_W-1:0] data_next;
    logic              sync_hit;

    // The fill count keeps the reset value of sync_sr from ever taking part in a match.
    always_comb begin
        sync_next = {sync_sr[SYNC_W-2:0], y};
        fill_next = (fill_cnt == FILL_FULL) ? fill_cnt : fill_cnt + FILL_W'(1);
        data_next = {data_sr[DATA_W-2:0], y};
        sync_hit  = (sync_next == SYNC_PAT) && (fill_next == FILL_FULL);
    end

`ifndef PARITY_CHK_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= HUNT;
            sync_sr    <= '0;
            fill_cnt   <= '0;
            bit_cnt    <= '0;
            data_sr    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            locked     <= 1'b0;
            frame_cnt  <= '0;
`ifdef PARITY_CHK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            if (en) begin
                unique case (state)
                    HUNT: begin
                        sync_sr  <= sync_next;
                        fill_cnt <= fill_next;
                        if (sync_hit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            locked  <= 1'b1;
                        end
                    end
                    DATA: begin
                        data_sr <= data_next;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_LAST) begin
`ifdef PARITY_CHK_EN
                            state <= PARITY;
`else
                            state      <= HUNT;
                            locked     <= 1'b0;
                            sync_sr    <= '0;
                            fill_cnt   <= '0;
                            data_out   <= data_next;
                            data_valid <= 1'b1;
                            if (frame_cnt != '1)
                                frame_cnt <= frame_cnt + CNT_W'(1);
`endif
                        end
                    end
                    PARITY: begin
                        state <= HUNT;
`ifdef PARITY_CHK_EN
                        // Bad-parity frames are still delivered and counted.
                        locked     <= 1'b0;
                        sync_sr    <= '0;
                        fill_cnt   <= '0;
                        data_out   <= data_sr;
                        data_valid <= 1'b1;
                        parity_err <= ^{data_sr, y};
                        if (frame_cnt != '1)
                            frame_cnt <= frame_cnt + CNT_W'(1);
`endif
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
